// File: rtl/nes_pad_pkg.sv
// ---------------------------------------------------------------------------
// nes_pad_pkg
//   Shared definitions for the NES controller reader.
//   - pad_state_t : reader FSM states
//   - BTN_*       : bit positions of each button in the button word (the
//                   order the NES core's joypad shifter expects)
//   - cnt_width() : counter width helper that never returns 0
// ---------------------------------------------------------------------------
package nes_pad_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LATCH,
      SETTLE,
      PULSE,
      LOW,
      DONE
   } pad_state_t;

   localparam int NUM_BUTTONS = 8;

   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;

   // Width of a counter that must hold 0..n-1; at least one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/nes_pad_sync.sv
// ---------------------------------------------------------------------------
// nes_pad_sync
//   Generic two-flop synchroniser for asynchronous inputs.
//   Parameters:
//     WIDTH     - number of independent bits
//     RESET_VAL - value both flop stages take while reset_n is low
//   Ports:
//     clk     in   destination clock
//     reset_n in   asynchronous active-low reset
//     d       in   asynchronous input bits
//     q       out  synchronised bits, two clk edges behind d
// ---------------------------------------------------------------------------
module nes_pad_sync #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic meta_reg;
         logic sync_reg;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               meta_reg <= RESET_VAL[gi];
               sync_reg <= RESET_VAL[gi];
            end else begin
               meta_reg <= d[gi];
               sync_reg <= meta_reg;
            end
         end

         assign q[gi] = sync_reg;
      end
   endgenerate

endmodule

// File: rtl/nes_pad_reader.sv
// ---------------------------------------------------------------------------
// nes_pad_reader
//   Host-side reader for a physical NES controller (CD4021 shift register).
//   Periodically strobes pad_latch, clocks the pad with pad_clk and samples
//   pad_data, presenting an active-high 8-bit button word
//   (bit 0 = A, 1 = B, 2 = Select, 3 = Start, 4 = Up, 5 = Down,
//    6 = Left, 7 = Right).
//
//   Parameters:
//     CLK_DIV     - clk cycles per timing tick (minimum 4)
//     POLL_TICKS  - ticks spent in IDLE between automatic polls
//     LATCH_TICKS - ticks for which pad_latch is held high
//
//   Ports:
//     clk           in   system clock (NES core domain)
//     reset_n       in   asynchronous active-low reset
//     poll_req      in   single-cycle request for an immediate poll
//     pad_data      in   serial data from pad, active-low, asynchronous
//     pad_latch     out  parallel-load strobe to the pad, active-high
//     pad_clk       out  shift clock to the pad, idles low
//     buttons       out  last completed read, active-high
//     buttons_valid out  one-cycle pulse when buttons is written
//     busy          out  high from leaving IDLE until the DONE cycle ends
//
//   Optional build macro NES_PAD_DEBOUNCE_EN: buttons only takes a new read
//   when it matches the previous raw read (two consecutive identical polls).
// ---------------------------------------------------------------------------
module nes_pad_reader
   import nes_pad_pkg::*;
#(
   parameter int CLK_DIV     = 64,
   parameter int POLL_TICKS  = 4096,
   parameter int LATCH_TICKS = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   poll_req,
   input  logic                   pad_data,
   output logic                   pad_latch,
   output logic                   pad_clk,
   output logic [NUM_BUTTONS-1:0] buttons,
   output logic                   buttons_valid,
   output logic                   busy
);

   localparam int PRESC_W = cnt_width(CLK_DIV);
   localparam int POLL_W  = cnt_width(POLL_TICKS);
   localparam int LATCH_W = cnt_width(LATCH_TICKS);

   pad_state_t                 state_reg;
   logic [PRESC_W-1:0]         presc_reg;
   logic [POLL_W-1:0]          poll_cnt_reg;
   logic [LATCH_W-1:0]         latch_cnt_reg;
   logic [2:0]                 bit_idx_reg;
   logic [NUM_BUTTONS-2:0]     shift_reg;
   logic [NUM_BUTTONS-1:0]     buttons_reg;
   logic                       valid_reg;
   logic                       pad_latch_reg;
   logic                       pad_clk_reg;
   logic                       busy_reg;
`ifdef NES_PAD_DEBOUNCE_EN
   logic [NUM_BUTTONS-1:0]     prev_raw_reg;
`endif

   logic                       pad_sync;
   logic                       tick;
   logic                       poll_due;
   logic [NUM_BUTTONS-1:0]     raw_next;

   // pad_data floats high when no pad is plugged in, so the synchroniser
   // resets to the "released" level.
   nes_pad_sync #(
      .WIDTH     (1),
      .RESET_VAL (1'b1)
   ) u_pad_data_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (pad_data),
      .q       (pad_sync)
   );

   assign tick     = (presc_reg == PRESC_W'(CLK_DIV - 1));
   assign poll_due = poll_req || (tick && (poll_cnt_reg == POLL_W'(POLL_TICKS - 1)));

   // Bits are shifted in from the top, so after the seventh sample the first
   // bit read (A) sits in shift_reg[0]. The eighth bit is taken straight
   // from the synchroniser on the final LOW tick, giving the full raw word
   // (active-low) in the same edge that enters DONE.
   assign raw_next = {pad_sync, shift_reg};

   // Outputs are registered and written on the edge that enters each state,
   // so buttons/buttons_valid become visible exactly in the DONE cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         presc_reg     <= '0;
         poll_cnt_reg  <= '0;
         latch_cnt_reg <= '0;
         bit_idx_reg   <= '0;
         shift_reg     <= '0;
         buttons_reg   <= '0;
         valid_reg     <= 1'b0;
         pad_latch_reg <= 1'b0;
         pad_clk_reg   <= 1'b0;
         busy_reg      <= 1'b0;
`ifdef NES_PAD_DEBOUNCE_EN
         prev_raw_reg  <= 8'hFF;
`endif
      end else begin
         valid_reg <= 1'b0;
         presc_reg <= tick ? '0 : presc_reg + PRESC_W'(1);

         case (state_reg)
            IDLE: begin
               // poll_req coinciding with expiry is covered by the same
               // branch, so it cannot produce a second poll.
               if (poll_due) begin
                  state_reg     <= LATCH;
                  presc_reg     <= '0;
                  poll_cnt_reg  <= '0;
                  latch_cnt_reg <= '0;
                  pad_latch_reg <= 1'b1;
                  busy_reg      <= 1'b1;
               end else if (tick) begin
                  poll_cnt_reg <= poll_cnt_reg + POLL_W'(1);
               end
            end

            LATCH: begin
               if (tick) begin
                  if (latch_cnt_reg == LATCH_W'(LATCH_TICKS - 1)) begin
                     state_reg     <= SETTLE;
                     presc_reg     <= '0;
                     pad_latch_reg <= 1'b0;
                  end else begin
                     latch_cnt_reg <= latch_cnt_reg + LATCH_W'(1);
                  end
               end
            end

            SETTLE: begin
               // Sampling at the end of the tick leaves at least CLK_DIV-2
               // cycles after the line settled, covering synchroniser delay.
               if (tick) begin
                  shift_reg   <= {pad_sync, shift_reg[NUM_BUTTONS-2:1]};
                  bit_idx_reg <= 3'd1;
                  state_reg   <= PULSE;
                  presc_reg   <= '0;
                  pad_clk_reg <= 1'b1;
               end
            end

            PULSE: begin
               if (tick) begin
                  state_reg   <= LOW;
                  presc_reg   <= '0;
                  pad_clk_reg <= 1'b0;
               end
            end

            LOW: begin
               if (tick) begin
                  bit_idx_reg <= bit_idx_reg + 3'd1;
                  presc_reg   <= '0;
                  if (bit_idx_reg == 3'd7) begin
                     // Last bit: no trailing pad_clk pulse.
                     state_reg <= DONE;
`ifdef NES_PAD_DEBOUNCE_EN
                     prev_raw_reg <= raw_next;
                     if (raw_next == prev_raw_reg) begin
                        buttons_reg <= ~raw_next;
                        valid_reg   <= 1'b1;
                     end
`else
                     buttons_reg <= ~raw_next;
                     valid_reg   <= 1'b1;
`endif
                  end else begin
                     shift_reg   <= {pad_sync, shift_reg[NUM_BUTTONS-2:1]};
                     state_reg   <= PULSE;
                     pad_clk_reg <= 1'b1;
                  end
               end
            end

            DONE: begin
               state_reg <= IDLE;
               presc_reg <= '0;
               busy_reg  <= 1'b0;
            end

            default: begin
               state_reg     <= IDLE;
               presc_reg     <= '0;
               pad_latch_reg <= 1'b0;
               pad_clk_reg   <= 1'b0;
               busy_reg      <= 1'b0;
            end
         endcase
      end
   end

   assign pad_latch     = pad_latch_reg;
   assign pad_clk       = pad_clk_reg;
   assign buttons       = buttons_reg;
   assign buttons_valid = valid_reg;
   assign busy          = busy_reg;

endmodule

// File: tb/tb_nes_pad_reader.sv
// ---------------------------------------------------------------------------
// tb_nes_pad_reader
//   Bench for nes_pad_reader with a behavioural CD4021 pad model whose
//   serial output settles after a random glitchy delay. Expected button
//   words are queued when each poll is set up; a monitor pops them on every
//   buttons_valid pulse. Honours NES_PAD_DEBOUNCE_EN when defined.
// ---------------------------------------------------------------------------
module tb_nes_pad_reader;

   localparam int CLK_DIV     = 4;
   localparam int POLL_TICKS  = 8;
   localparam int LATCH_TICKS = 2;

   logic       clk      = 1'b0;
   logic       reset_n  = 1'b1;
   logic       poll_req = 1'b0;
   logic       pad_data = 1'b1;
   logic       pad_latch;
   logic       pad_clk;
   logic [7:0] buttons;
   logic       buttons_valid;
   logic       busy;

   always #5 clk = ~clk;

   nes_pad_reader #(
      .CLK_DIV     (CLK_DIV),
      .POLL_TICKS  (POLL_TICKS),
      .LATCH_TICKS (LATCH_TICKS)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .poll_req      (poll_req),
      .pad_data      (pad_data),
      .pad_latch     (pad_latch),
      .pad_clk       (pad_clk),
      .buttons       (buttons),
      .buttons_valid (buttons_valid),
      .busy          (busy)
   );

   int tests = 0;
   int fails = 0;
   logic [7:0] exp_q[$];
`ifdef NES_PAD_DEBOUNCE_EN
   logic [7:0] prev_model = 8'hFF;
`endif

   // ---------------- CD4021 model: active-low parallel inputs ------------
   logic [7:0] pad_par = 8'hFF;
   logic [7:0] sr      = 8'hFF;

   initial forever begin
      @(posedge pad_clk or posedge pad_latch);
      if (pad_latch) sr = pad_par;
      else           sr = {1'b1, sr[7:1]};
   end

   // Output glitches for a random while, then settles within 45 time units
   // (under 2 clk periods remain far before any sample point).
   initial forever begin
      int n;
      @(posedge pad_clk or posedge pad_latch);
      n = int'($urandom_range(0, 3));
      for (int k = 0; k < n; k++) begin
         #($urandom_range(1, 9));
         pad_data = 1'($urandom);
      end
      #($urandom_range(1, 9));
      pad_data = sr[0];
   end

   // ---------------- checking helpers ------------------------------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic expect_poll(input logic [7:0] raw);
`ifdef NES_PAD_DEBOUNCE_EN
      if (raw == prev_model) exp_q.push_back(~raw);
      prev_model = raw;
`else
      exp_q.push_back(~raw);
`endif
   endtask

   // Wait for the next poll to start and complete, bounded.
   task automatic wait_poll(input string name);
      int n;
      bit ok;
      n = 0;
      while (!busy && n < 300) begin @(negedge clk); n++; end
      n = 0;
      while (busy && n < 300) begin @(negedge clk); n++; end
      ok = !busy;
      check(name, 32'(ok), 32'd1);
   endtask

   // ---------------- monitor ---------------------------------------------
   int   cyc = 0;
   int   latch_rises = 0, latch_rise_cyc = 0, latch_hi = 0;
   int   clk_rises = 0, valid_cyc = 0;
   logic pl_d = 1'b0, pc_d = 1'b0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      logic [7:0] e;
      @(negedge clk);
      if (pad_latch && !pl_d) begin
         latch_rises++;
         latch_rise_cyc = cyc;
      end
      if (pad_latch) latch_hi++;
      if (pad_clk && !pc_d) clk_rises++;
      if (buttons_valid) begin
         valid_cyc = cyc;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_valid: got pulse with buttons %02h, required no pulse", buttons);
         end else begin
            e = exp_q.pop_front();
            $display("[TB] poll at cycle %0d: buttons=%02h expected=%02h", cyc, buttons, e);
            check("buttons", 32'(buttons), 32'(e));
         end
      end
      pl_d = pad_latch;
      pc_d = pad_clk;
   end

   // ---------------- stimulus --------------------------------------------
   initial begin
      int rel, l0, c0, h0, n;
      logic [7:0] dbl [4];
      dbl[0] = 8'hFE; dbl[1] = 8'hFE; dbl[2] = 8'hFC; dbl[3] = 8'hFC;

      #2 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_latch",   32'(pad_latch),     32'd0);
      check("rst_pad_clk", 32'(pad_clk),       32'd0);
      check("rst_buttons", 32'(buttons),       32'd0);
      check("rst_valid",   32'(buttons_valid), 32'd0);
      check("rst_busy",    32'(busy),          32'd0);

      // Idle pad, automatic poll after 8 ticks.
      pad_par = 8'hFF;
      expect_poll(8'hFF);
      l0 = latch_rises; c0 = clk_rises; h0 = latch_hi; rel = cyc;
      reset_n = 1'b1;
      wait_poll("poll_idle_done");
      check("latch_delay",   32'(latch_rise_cyc - rel),       32'd32);
      check("latch_rises",   32'(latch_rises - l0),           32'd1);
      check("latch_width",   32'(latch_hi - h0),              32'd8);
      check("clk_pulses",    32'(clk_rises - c0),             32'd7);
      check("valid_latency", 32'(valid_cyc - latch_rise_cyc), 32'd68);

      // A + Start + Right held, two identical polls.
      pad_par = 8'b0111_0110;
      for (int i = 0; i < 2; i++) begin
         expect_poll(pad_par);
         wait_poll("poll_asr_done");
      end

      // Sequence 01, 01, 03, 03 (active-high).
      for (int i = 0; i < 4; i++) begin
         pad_par = dbl[i];
         expect_poll(pad_par);
         wait_poll("poll_seq_done");
      end

      // Reset during the pad_clk pulse of bit 4.
      pad_par = 8'h00;
      c0 = clk_rises;
      n = 0;
      while ((clk_rises - c0) < 4 && n < 400) begin @(negedge clk); n++; end
      check("reach_bit4_pulse", 32'(pad_clk), 32'd1);
      #1 reset_n = 1'b0;
      #1;
      check("abort_pad_clk", 32'(pad_clk),   32'd0);
      check("abort_latch",   32'(pad_latch), 32'd0);
      check("abort_buttons", 32'(buttons),   32'd0);
      check("abort_busy",    32'(busy),      32'd0);
`ifdef NES_PAD_DEBOUNCE_EN
      prev_model = 8'hFF;
`endif
      @(negedge clk);
      l0 = latch_rises;
      pad_par = 8'b0111_0110;
      expect_poll(pad_par);
      reset_n = 1'b1;

      // poll_req: latch follows one cycle later; repeat while busy is dropped.
      repeat (9) @(negedge clk);
      check("req_pre_latch", 32'(pad_latch), 32'd0);
      poll_req = 1'b1;
      @(negedge clk);
      poll_req = 1'b0;
      check("req_latch", 32'(pad_latch), 32'd1);
      repeat (20) @(negedge clk);
      check("req_busy", 32'(busy), 32'd1);
      poll_req = 1'b1;
      @(negedge clk);
      poll_req = 1'b0;
      wait_poll("req_poll_done");
      check("req_single_latch", 32'(latch_rises - l0), 32'd1);

      // Random data with glitchy, random-phase pad output.
      for (int i = 0; i < 200; i++) begin
         pad_par = 8'($urandom);
         expect_poll(pad_par);
         wait_poll("sweep_done");
      end

      repeat (5) @(negedge clk);
      check("pending_expected", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/nes_pad_reader.md
Name: nes_pad_reader

Overview:
- Host-side reader for a physical NES controller (CD4021 shift register) on a board header.
- Periodically drives the pad latch and clock lines, samples the serial data line and presents an 8-bit active-high button word.
- The button word uses the same bit order the NES core's joypad shifter expects: bit 0 = A, 1 = B, 2 = Select, 3 = Start, 4 = Up, 5 = Down, 6 = Left, 7 = Right.
- Sits in the top level; its output is ORed into the player-1 joypad word alongside the keyboard joystick.

Parameters:
- CLK_DIV, 64: system clk cycles per timing tick; minimum 4.
- POLL_TICKS, 4096: ticks between automatic polls.
- LATCH_TICKS, 2: ticks for which pad_latch is held high.

Ports:
- clk  in  1  system clock, the NES core clock domain.
- reset_n  in  1  asynchronous active-low reset.
- poll_req  in  1  single-cycle request for an immediate poll; ignored while busy.
- pad_data  in  1  serial data from the pad; active-low (0 = pressed), pulled up off-chip; asynchronous.
- pad_latch  out  1  parallel-load strobe to the pad; active-high.
- pad_clk  out  1  shift clock to the pad; idles low, rising edge shifts.
- buttons  out  8  last completed read; active-high, order as in Overview.
- buttons_valid  out  1  one-cycle pulse when buttons is updated.
- busy  out  1  high from leaving IDLE until the DONE cycle completes.

Behaviour:
- Reset (asynchronous, reset_n low):
  - All outputs 0.
  - FSM to IDLE; tick prescaler, poll counter, bit index and shift register cleared.
  - The 2-FF synchroniser on pad_data resets to 1.
- Tick:
  - Prescaler counts 0..CLK_DIV-1 and wraps; tick asserts on the wrap cycle.
  - Prescaler is reset to 0 on every state entry, so each state lasts exactly N full ticks.
- IDLE:
  - pad_latch = 0, pad_clk = 0.
  - Poll counter increments per tick.
  - At POLL_TICKS, or on poll_req: clear the counter and go to LATCH. poll_req in the same cycle as the counter expiry yields a single poll.
- LATCH: pad_latch = 1 for LATCH_TICKS ticks, then SETTLE.
- SETTLE:
  - pad_latch = 0 for 1 tick.
  - On the final tick, sample synchronised pad_data into shift[0]; bit index = 1; go to PULSE.
- PULSE: pad_clk = 1 for 1 tick, then LOW.
- LOW:
  - pad_clk = 0 for 1 tick.
  - On the final tick, sample into shift[index] and increment index.
  - If the sampled index was 7, go to DONE; otherwise go to PULSE.
- DONE, 1 cycle:
  - buttons <= ~shift; buttons_valid = 1; go to IDLE.
  - busy is still high in this cycle and drops on the next.
- Latency: from pad_latch rising to the buttons_valid cycle = (LATCH_TICKS + 1 + 14) × CLK_DIV cycles.
  - Defaults: 17 × 64 = 1088 cycles.
  - pad_latch rises 1 cycle after the triggering event.
- Bus activity: exactly 7 pad_clk pulses per poll. The 8th bit is read without a trailing pulse.
- poll_req while busy: dropped, not queued.
- Sampling point: the end of each settle/low tick, which is ≥ CLK_DIV − 2 cycles after the edge; this absorbs synchroniser latency.
- Disconnected pad: pull-up gives all 1s, so buttons = 8'h00. No error flag.
- Reset mid-poll: the transaction is aborted, pad lines go low immediately, and buttons clears to 0.

Optional Feature:
- Macro: NES_PAD_DEBOUNCE_EN.
- Defined:
  - An extra 8-bit register holds the previous raw read.
  - In DONE, buttons updates only if the new raw read equals the previous one.
  - buttons_valid pulses only when buttons is written.
  - The previous-read register always updates and resets to 8'hFF.
- Undefined: every completed poll writes buttons and pulses buttons_valid.

Decomposition:
- Shared package nes_pad_pkg:
  - State encoding: IDLE, LATCH, SETTLE, PULSE, LOW, DONE.
  - Button bit-index constants: BTN_A = 0 … BTN_RIGHT = 7.
- Sub-module nes_pad_sync: generic 2-FF synchroniser with reset value parameter; used for pad_data.
- Everything else stays in one module.

Test Plan:
- Common setup: pad model is a 4021 behavioural model. Default for all scenarios: CLK_DIV = 4, LATCH_TICKS = 2; POLL_TICKS = 8 unless stated.
- Reset then idle, pad idle (all released): after 8 ticks (32 cycles) pad_latch is high for 8 cycles, 7 pad_clk pulses follow, buttons_valid pulses at latch rise + 68 cycles, buttons = 8'h00.
- Pad holds A + Start + Right (parallel 8'b0111_0110, bit 0 first out): buttons = 8'h89.
- With POLL_TICKS = 4096, poll_req pulsed at cycle 10: pad_latch rises at cycle 11. A second poll_req while busy: no additional latch pulse, exactly one buttons_valid.
- reset_n asserted during PULSE of bit 4: pad_clk and pad_latch go to 0 in the same cycle, buttons = 0, busy = 0, and the next poll completes normally.
- With NES_PAD_DEBOUNCE_EN, pad reads 8'h01, 8'h01, 8'h03, 8'h03 across polls: buttons_valid on polls 2 and 4 only, buttons = 8'h01 then 8'h03.
- Pad toggles pad_data asynchronously mid-tick: the sampled value equals the level present ≥ 2 cycles before the sample point. Check with a random-phase sweep over 200 polls.
